// File: rtl/corr_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the lag-correlator frame sequencer.
// Widths derive from M_LAGS / N_BINS with a one-bit floor so single-entry counters still have a port.
package corr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        REQ,
        EMIT,
        DONE
    } corr_state_e;

    localparam int CORR_N_BINS = 6;
    localparam int CORR_M_LAGS = 3;
    localparam int CORR_DW     = 32;
    localparam int CORR_CW     = 16;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    localparam int CORR_LW = clog2_min1(CORR_M_LAGS);
    localparam int CORR_SW = clog2_min1(CORR_N_BINS);

endpackage

// File: rtl/corr_seq_ctrl_if.sv
// Normalizer request/ack and result stream between the sequencer (master) and its datapath (slave).
interface corr_seq_ctrl_if #(
    parameter int DW = 32,
    parameter int CW = 16,
    parameter int LW = 2
);
    logic        [LW-1:0] lag_sel;
    logic signed [DW-1:0] lag_sum;
    logic                 norm_req;
    logic signed [DW-1:0] norm_num;
    logic        [CW-1:0] norm_den;
    logic                 norm_ack;
    logic signed [DW-1:0] norm_quot;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic        [LW-1:0] out_lag;

    modport master (
        output lag_sel, norm_req, norm_num, norm_den, out_valid, out_data, out_lag,
        input  lag_sum, norm_ack, norm_quot, out_ready
    );

    modport slave (
        input  lag_sel, norm_req, norm_num, norm_den, out_valid, out_data, out_lag,
        output lag_sum, norm_ack, norm_quot, out_ready
    );
endinterface

// File: rtl/corr_seq_ctrl_tc_counter.sv
// Up-counter with synchronous clear, wrapping to zero after MAX; tc_o flags cnt_o == MAX.
// Clear has priority over enable.
module corr_tc_counter #(
    parameter int W   = 2,
    parameter int MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o  = (cnt_q == W'(MAX));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/corr_seq_ctrl.sv
// Frame sequencer: clear/accumulate the MAC chain, then drain lag sums one by one through the shared normalizer.
// Latency: result valid 1 cycle after norm_ack; out_valid held until out_ready. CORR_AUTO_RESTART_EN repeats frames.
module corr_seq_ctrl
    import corr_pkg::*;
#(
    parameter int N_BINS = CORR_N_BINS,
    parameter int M_LAGS = CORR_M_LAGS,
    parameter int DW     = CORR_DW,
    parameter int CW     = CORR_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             sample_valid,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    corr_seq_ctrl_if.master  bus
);
    localparam int LW = clog2_min1(M_LAGS);
    localparam int SW = clog2_min1(N_BINS);

    corr_state_e          state_q;
    logic                 mac_clr_q;
    logic                 norm_req_q;
    logic                 out_valid_q;
    logic signed [DW-1:0] out_data_q;
    logic        [LW-1:0] out_lag_q;
    logic                 busy_q;
    logic                 frame_done_q;
    logic                 overrun_q;

    logic          cnt_clr;
    logic          smp_tc;
    logic [SW-1:0] smp_cnt_unused;
    logic          lag_en;
    logic          lag_tc;
    logic [LW-1:0] lag_cnt;

    assign mac_en  = (state_q == ACCUM) && sample_valid;
    assign cnt_clr = (state_q == CLEAR) || abort;
    assign lag_en  = (state_q == EMIT) && bus.out_ready;

    corr_tc_counter #(.W(SW), .MAX(N_BINS - 1)) u_smp_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (mac_en),
        .clr_i (cnt_clr),
        .cnt_o (smp_cnt_unused),
        .tc_o  (smp_tc)
    );

    corr_tc_counter #(.W(LW), .MAX(M_LAGS - 1)) u_lag_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (lag_en),
        .clr_i (cnt_clr),
        .cnt_o (lag_cnt),
        .tc_o  (lag_tc)
    );

    // Request operands are forced to zero outside REQ so idle outputs stay quiet.
    assign bus.lag_sel   = lag_cnt;
    assign bus.norm_req  = norm_req_q;
    assign bus.norm_num  = norm_req_q ? bus.lag_sum : '0;
    assign bus.norm_den  = norm_req_q ? (CW'(N_BINS) - CW'(lag_cnt)) : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_lag   = out_lag_q;
    assign mac_clr       = mac_clr_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign overrun       = overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mac_clr_q    <= 1'b0;
            norm_req_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_lag_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            mac_clr_q    <= 1'b0;
            frame_done_q <= 1'b0;
            if (sample_valid && (state_q inside {CLEAR, REQ, EMIT, DONE})) begin
                overrun_q <= 1'b1;
            end
            if (abort && (state_q != IDLE)) begin
                state_q     <= IDLE;
                norm_req_q  <= 1'b0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            state_q   <= CLEAR;
                            mac_clr_q <= 1'b1;
                            busy_q    <= 1'b1;
                            overrun_q <= 1'b0;
                        end
                    end
                    CLEAR: state_q <= ACCUM;
                    ACCUM: begin
                        if (sample_valid && smp_tc) begin
                            state_q    <= REQ;
                            norm_req_q <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (bus.norm_ack) begin
                            state_q     <= EMIT;
                            norm_req_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= bus.norm_quot;
                            out_lag_q   <= lag_cnt;
                        end
                    end
                    EMIT: begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            if (lag_tc) begin
                                state_q      <= DONE;
                                frame_done_q <= 1'b1;
                            end else begin
                                state_q    <= REQ;
                                norm_req_q <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
`ifdef CORR_AUTO_RESTART_EN
                        state_q   <= CLEAR;
                        mac_clr_q <= 1'b1;
                        overrun_q <= 1'b0;
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`endif
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
